// File: rtl/amo_lock_profiler.sv
// rtl/amo_lock_profiler.sv - per-lock acquire/contention/hold-time statistics with protocol checking
module amo_lock_profiler #(
    parameter int addr_width_p   = 28,
    parameter int x_cord_width_p = 6,
    parameter int y_cord_width_p = 6,
    parameter int els_p          = 8,
    parameter int cnt_width_p    = 32,
    parameter int idx_width_lp   = $clog2(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      ev_v_i,
    input  logic [1:0]                ev_type_i,
    input  logic [addr_width_p-1:0]   ev_addr_i,
    input  logic [x_cord_width_p-1:0] ev_x_i,
    input  logic [y_cord_width_p-1:0] ev_y_i,
    input  logic                      rd_v_i,
    input  logic [idx_width_lp-1:0]   rd_idx_i,
    output logic                      rd_v_o,
    output logic                      rd_entry_v_o,
    output logic [addr_width_p-1:0]   rd_addr_o,
    output logic                      rd_held_o,
    output logic [cnt_width_p-1:0]    rd_acq_cnt_o,
    output logic [cnt_width_p-1:0]    rd_fail_cnt_o,
    output logic [cnt_width_p-1:0]    rd_max_hold_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic                      overflow_o
);
    localparam logic [1:0] ev_acq_lp  = 2'd0;
    localparam logic [1:0] ev_rel_lp  = 2'd1;
    localparam logic [1:0] ev_fail_lp = 2'd2;

    logic                      valid_r [els_p];
    logic [addr_width_p-1:0]   addr_r  [els_p];
    logic                      held_r  [els_p];
    logic [x_cord_width_p-1:0] hx_r    [els_p];
    logic [y_cord_width_p-1:0] hy_r    [els_p];
    logic [cnt_width_p-1:0]    stamp_r [els_p];
    logic [cnt_width_p-1:0]    acq_r   [els_p];
    logic [cnt_width_p-1:0]    fail_r  [els_p];
    logic [cnt_width_p-1:0]    max_r   [els_p];
    logic [cnt_width_p-1:0]    timer_r;

    logic                      hit_v, free_v;
    logic [idx_width_lp-1:0]   hit_idx, free_idx, tgt_idx;
    logic                      is_acq, is_rel, is_fail;
    logic                      alloc_ok;
    logic [cnt_width_p-1:0]    hold_time;
    logic                      ev_err_v;
    logic [1:0]                ev_err_code;

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        hit_v    = 1'b0;
        hit_idx  = '0;
        free_v   = 1'b0;
        free_idx = '0;
        for (int i = 0; i < els_p; i++) begin
            if (valid_r[i] && addr_r[i] == ev_addr_i) begin
                hit_v   = 1'b1;
                hit_idx = idx_width_lp'(i);
            end
        end
        // Scan downward so the lowest free index wins.
        for (int i = els_p - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_v   = 1'b1;
                free_idx = idx_width_lp'(i);
            end
        end
    end

    always_comb begin
        is_acq      = ev_v_i && ev_type_i == ev_acq_lp;
        is_rel      = ev_v_i && ev_type_i == ev_rel_lp;
        is_fail     = ev_v_i && ev_type_i == ev_fail_lp;
        tgt_idx     = hit_v ? hit_idx : free_idx;
        alloc_ok    = hit_v || free_v;
        hold_time   = timer_r - stamp_r[hit_idx];
        ev_err_v    = 1'b0;
        ev_err_code = 2'd0;
        if (is_acq && hit_v && held_r[hit_idx]) begin
            ev_err_v    = 1'b1;
            ev_err_code = 2'd1;
        end else if (is_rel && !(hit_v && held_r[hit_idx])) begin
            ev_err_v    = 1'b1;
            ev_err_code = 2'd2;
        end else if (is_rel && (hx_r[hit_idx] != ev_x_i || hy_r[hit_idx] != ev_y_i)) begin
            ev_err_v    = 1'b1;
            ev_err_code = 2'd3;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                valid_r[i] <= 1'b0;
                addr_r[i]  <= '0;
                held_r[i]  <= 1'b0;
                hx_r[i]    <= '0;
                hy_r[i]    <= '0;
                stamp_r[i] <= '0;
                acq_r[i]   <= '0;
                fail_r[i]  <= '0;
                max_r[i]   <= '0;
            end
            timer_r       <= '0;
            rd_v_o        <= 1'b0;
            rd_entry_v_o  <= 1'b0;
            rd_addr_o     <= '0;
            rd_held_o     <= 1'b0;
            rd_acq_cnt_o  <= '0;
            rd_fail_cnt_o <= '0;
            rd_max_hold_o <= '0;
            err_o         <= 1'b0;
            err_code_o    <= 2'd0;
            overflow_o    <= 1'b0;
        end else begin
            timer_r <= timer_r + 1'b1;
            rd_v_o  <= rd_v_i;
            // Reads sample the table before this edge's event lands.
            if (rd_v_i) begin
                rd_entry_v_o  <= valid_r[rd_idx_i];
                rd_addr_o     <= addr_r[rd_idx_i];
                rd_held_o     <= held_r[rd_idx_i];
                rd_acq_cnt_o  <= acq_r[rd_idx_i];
                rd_fail_cnt_o <= fail_r[rd_idx_i];
                rd_max_hold_o <= max_r[rd_idx_i];
            end
            if (ev_err_v && !err_o) begin
                err_o      <= 1'b1;
                err_code_o <= ev_err_code;
            end
            if (is_acq || is_fail) begin
                if (!alloc_ok) begin
                    overflow_o <= 1'b1;
                end else begin
                    if (!hit_v) begin
                        valid_r[tgt_idx] <= 1'b1;
                        addr_r[tgt_idx]  <= ev_addr_i;
                    end
                    if (is_acq) begin
                        held_r[tgt_idx]  <= 1'b1;
                        hx_r[tgt_idx]    <= ev_x_i;
                        hy_r[tgt_idx]    <= ev_y_i;
                        stamp_r[tgt_idx] <= timer_r;
                        acq_r[tgt_idx]   <= sat_inc(acq_r[tgt_idx]);
                    end else begin
                        fail_r[tgt_idx]  <= sat_inc(fail_r[tgt_idx]);
                    end
                end
            end
            if (is_rel && hit_v && held_r[hit_idx]) begin
                held_r[hit_idx] <= 1'b0;
                if (hold_time > max_r[hit_idx]) begin
                    max_r[hit_idx] <= hold_time;
                end
            end
        end
    end
endmodule

// File: tb/tb_amo_lock_profiler.sv
// tb/tb_amo_lock_profiler.sv - random and directed checks of amo_lock_profiler against a table model
module tb_amo_lock_profiler;
    localparam int AW = 28, XW = 6, YW = 6, EL = 8, CW = 8, IW = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic clk_i = 1'b0, reset_i = 1'b1;
    logic ev_v_i = 1'b0;
    logic [1:0] ev_type_i = '0;
    logic [AW-1:0] ev_addr_i = '0;
    logic [XW-1:0] ev_x_i = '0;
    logic [YW-1:0] ev_y_i = '0;
    logic rd_v_i = 1'b0;
    logic [IW-1:0] rd_idx_i = '0;
    logic rd_v_o, rd_entry_v_o, rd_held_o, err_o, overflow_o;
    logic [AW-1:0] rd_addr_o;
    logic [CW-1:0] rd_acq_cnt_o, rd_fail_cnt_o, rd_max_hold_o;
    logic [1:0] err_code_o;

    amo_lock_profiler #(.addr_width_p(AW), .x_cord_width_p(XW), .y_cord_width_p(YW),
                        .els_p(EL), .cnt_width_p(CW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ev_v_i(ev_v_i), .ev_type_i(ev_type_i),
        .ev_addr_i(ev_addr_i), .ev_x_i(ev_x_i), .ev_y_i(ev_y_i), .rd_v_i(rd_v_i),
        .rd_idx_i(rd_idx_i), .rd_v_o(rd_v_o), .rd_entry_v_o(rd_entry_v_o),
        .rd_addr_o(rd_addr_o), .rd_held_o(rd_held_o), .rd_acq_cnt_o(rd_acq_cnt_o),
        .rd_fail_cnt_o(rd_fail_cnt_o), .rd_max_hold_o(rd_max_hold_o), .err_o(err_o),
        .err_code_o(err_code_o), .overflow_o(overflow_o));

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit v; int a; bit h; int x; int y; int st; int acq; int fail; int mh;
    } ent_t;
    ent_t m [EL];
    int mtimer;
    bit m_err, m_ovf, m_rdv;
    int m_code;
    ent_t m_rd;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void raise(input int c);
        if (!m_err) begin m_err = 1; m_code = c; end
    endfunction

    // Model: table of locks, applied once per clock from the sampled inputs.
    always @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < EL; i++) m[i] = '{default: 0};
            m_rd = '{default: 0};
            mtimer = 0; m_err = 0; m_code = 0; m_ovf = 0; m_rdv = 0;
        end else begin
            int hit, fr, t;
            m_rdv = rd_v_i;
            if (rd_v_i) m_rd = m[rd_idx_i];
            hit = -1; fr = -1;
            for (int i = 0; i < EL; i++) begin
                if (m[i].v && m[i].a == int'(ev_addr_i)) hit = i;
                if (!m[i].v && fr < 0) fr = i;
            end
            if (ev_v_i && (ev_type_i == 0 || ev_type_i == 2)) begin
                t = (hit >= 0) ? hit : fr;
                if (t < 0) m_ovf = 1;
                else begin
                    if (hit < 0) begin m[t].v = 1; m[t].a = int'(ev_addr_i); end
                    if (ev_type_i == 0) begin
                        if (m[t].h) raise(1);
                        m[t].h = 1; m[t].x = ev_x_i; m[t].y = ev_y_i; m[t].st = mtimer;
                        if (m[t].acq < MAXC) m[t].acq++;
                    end else if (m[t].fail < MAXC) m[t].fail++;
                end
            end else if (ev_v_i && ev_type_i == 1) begin
                if (hit < 0 || !m[hit].h) raise(2);
                else begin
                    int hold;
                    if (m[hit].x != int'(ev_x_i) || m[hit].y != int'(ev_y_i)) raise(3);
                    m[hit].h = 0;
                    hold = (mtimer - m[hit].st) & MAXC;
                    if (hold > m[hit].mh) m[hit].mh = hold;
                end
            end
            mtimer = (mtimer + 1) & MAXC;
        end
    end

    always @(negedge clk_i) begin
        chk("rd_v", rd_v_o, m_rdv);
        chk("entry_v", rd_entry_v_o, m_rd.v);
        chk("addr", rd_addr_o, m_rd.a);
        chk("held", rd_held_o, m_rd.h);
        chk("acq", rd_acq_cnt_o, m_rd.acq);
        chk("fail", rd_fail_cnt_o, m_rd.fail);
        chk("max_hold", rd_max_hold_o, m_rd.mh);
        chk("err", err_o, m_err);
        chk("err_code", err_code_o, m_code);
        chk("overflow", overflow_o, m_ovf);
    end

    task automatic tick(); @(negedge clk_i); endtask
    task automatic do_reset(); reset_i = 1; tick(); tick(); reset_i = 0; endtask
    task automatic ev(input int ty, input int a, input int x, input int y);
        ev_v_i = 1; ev_type_i = 2'(ty); ev_addr_i = AW'(a); ev_x_i = XW'(x); ev_y_i = YW'(y);
        tick();
        ev_v_i = 0;
    endtask
    task automatic rd(input int idx);
        rd_v_i = 1; rd_idx_i = IW'(idx); tick(); rd_v_i = 0;
    endtask
    task automatic wait_timer(input int val);
        int n = 0;
        while (mtimer != val && n < 600) begin tick(); n++; end
        if (mtimer != val) chk("timer_wait_timeout", mtimer, val);
    endtask

    initial begin
        tick();
        do_reset();
        for (int i = 0; i < EL; i++) begin
            rd(i);
            chk("lit_reset_rdv", rd_v_o, 1);
            chk("lit_reset_entry", rd_entry_v_o, 0);
            chk("lit_reset_acq", rd_acq_cnt_o, 0);
        end
        chk("lit_reset_err", err_o, 0);
        chk("lit_reset_ovf", overflow_o, 0);

        // Hold of 15 cycles, then contention and a 40-cycle hold.
        ev(0, 'h100, 1, 2); repeat (14) tick(); ev(1, 'h100, 1, 2);
        rd(0);
        chk("lit_addr", rd_addr_o, 'h100); chk("lit_held", rd_held_o, 0);
        chk("lit_acq1", rd_acq_cnt_o, 1); chk("lit_fail0", rd_fail_cnt_o, 0);
        chk("lit_hold15", rd_max_hold_o, 15);
        ev(0, 'h100, 1, 2); ev(2, 'h100, 3, 3); ev(2, 'h100, 4, 1); ev(2, 'h100, 0, 5);
        repeat (36) tick(); ev(1, 'h100, 1, 2);
        rd(0);
        chk("lit_acq2", rd_acq_cnt_o, 2); chk("lit_fail3", rd_fail_cnt_o, 3);
        chk("lit_hold40", rd_max_hold_o, 40); chk("lit_noerr", err_o, 0);

        // Wrong-holder release, then double acquire keeps first code.
        ev(0, 'h100, 1, 2); ev(1, 'h100, 3, 3);
        chk("lit_err3", err_o, 1); chk("lit_code3", err_code_o, 3);
        ev(0, 'h100, 1, 2); ev(0, 'h100, 1, 2);
        chk("lit_code_sticky", err_code_o, 3);

        // Timer wrap hold and same-cycle read.
        wait_timer('hF0); ev(0, 'h200, 0, 0);
        wait_timer('h10);
        rd_v_i = 1; rd_idx_i = 1; ev(1, 'h200, 0, 0); rd_v_i = 0;
        chk("lit_wrap_prev_held", rd_held_o, 1); chk("lit_wrap_prev_hold", rd_max_hold_o, 0);
        rd(1);
        chk("lit_wrap_held", rd_held_o, 0); chk("lit_wrap_hold", rd_max_hold_o, 'h20);

        // Table full, then saturation.
        do_reset();
        for (int i = 0; i < EL; i++) ev(2, 'h1000 + i, 0, 0);
        ev(0, 'h2000, 1, 1);
        chk("lit_overflow", overflow_o, 1);
        for (int i = 0; i < EL; i++) begin
            rd(i);
            chk("lit_full_addr", rd_addr_o, 'h1000 + i); chk("lit_full_acq", rd_acq_cnt_o, 0);
        end
        repeat (260) ev(2, 'h1003, 2, 2);
        rd(3);
        chk("lit_sat", rd_fail_cnt_o, MAXC);

        // Randomized traffic over a 10-address pool with occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset_i   = ($urandom_range(0, 499) == 0);
            ev_v_i    = $urandom_range(0, 3) != 0;
            ev_type_i = 2'($urandom_range(0, 3));
            ev_addr_i = AW'('h40 * $urandom_range(0, 9));
            ev_x_i    = XW'($urandom_range(0, 2));
            ev_y_i    = YW'($urandom_range(0, 2));
            rd_v_i    = $urandom_range(0, 1) != 0;
            rd_idx_i  = IW'($urandom_range(0, EL - 1));
            tick();
        end
        reset_i = 0; ev_v_i = 0; rd_v_i = 0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
